// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a single-port byte RAM with synchronous read.
// Accepted commands reach the RAM one cycle later; read data returns to its owner two cycles after accept.
module ram_port_arbiter #(
  parameter int ram_addr_width = 19,
  parameter int prio_mode      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      m0_req_valid,
  output logic                      m0_req_ready,
  input  logic                      m0_req_we,
  input  logic [ram_addr_width-1:0] m0_req_addr,
  input  logic [7:0]                m0_req_wdata,
  output logic                      m0_rsp_valid,
  output logic [7:0]                m0_rsp_rdata,
  input  logic                      m1_req_valid,
  output logic                      m1_req_ready,
  input  logic                      m1_req_we,
  input  logic [ram_addr_width-1:0] m1_req_addr,
  input  logic [7:0]                m1_req_wdata,
  output logic                      m1_rsp_valid,
  output logic [7:0]                m1_rsp_rdata,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [ram_addr_width-1:0] ram_addr,
  output logic [7:0]                ram_wdata,
  input  logic [7:0]                ram_rdata
);

  typedef enum logic {OWNER_M0 = 1'b0, OWNER_M1 = 1'b1} owner_t;

  owner_t                      last_grant;
  owner_t                      tag_owner;
  logic                        tag_rd;
  logic                        grant_m0;
  logic                        grant_m1;
  logic                        accept;
  logic                        sel_we;
  logic [ram_addr_width-1:0]   sel_addr;
  logic [7:0]                  sel_wdata;

  always_comb begin
    grant_m0 = 1'b0;
    grant_m1 = 1'b0;
    if (!rst) begin
      if (m0_req_valid && m1_req_valid) begin
        // On a tie fixed mode always favours m0; round-robin hands it to whoever did not win last.
        if ((prio_mode != 0) || (last_grant == OWNER_M1)) begin
          grant_m0 = 1'b1;
        end else begin
          grant_m1 = 1'b1;
        end
      end else begin
        grant_m0 = m0_req_valid;
        grant_m1 = m1_req_valid;
      end
    end
  end

  assign m0_req_ready = grant_m0;
  assign m1_req_ready = grant_m1;
  assign accept       = grant_m0 | grant_m1;
  assign sel_we       = grant_m1 ? m1_req_we    : m0_req_we;
  assign sel_addr     = grant_m1 ? m1_req_addr  : m0_req_addr;
  assign sel_wdata    = grant_m1 ? m1_req_wdata : m0_req_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant   <= OWNER_M1;
      ram_en       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      tag_rd       <= 1'b0;
      tag_owner    <= OWNER_M0;
      m0_rsp_valid <= 1'b0;
      m1_rsp_valid <= 1'b0;
    end else begin
      if (accept) begin
        last_grant <= grant_m1 ? OWNER_M1 : OWNER_M0;
        ram_addr   <= sel_addr;
        ram_wdata  <= sel_wdata;
      end
      ram_en       <= accept;
      ram_we       <= accept & sel_we;
      // Stage one tags the RAM command; stage two lines up with the RAM's read data.
      tag_rd       <= accept & ~sel_we;
      tag_owner    <= grant_m1 ? OWNER_M1 : OWNER_M0;
      m0_rsp_valid <= tag_rd && (tag_owner == OWNER_M0);
      m1_rsp_valid <= tag_rd && (tag_owner == OWNER_M1);
    end
  end

  assign m0_rsp_rdata = ram_rdata;
  assign m1_rsp_rdata = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grants, RAM commands and read responses,
// and a negedge monitor compares the DUT against the queued expectations.
module tb_ram_port_arbiter;

  localparam int AW = 19;

  typedef struct {
    int             cyc;
    logic           we;
    logic [AW-1:0]  addr;
    logic [7:0]     data;
  } cmd_t;

  typedef struct {
    int             cyc;
    logic [7:0]     data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           m0_req_valid, m0_req_ready, m0_req_we, m0_rsp_valid;
  logic [AW-1:0]  m0_req_addr;
  logic [7:0]     m0_req_wdata, m0_rsp_rdata;
  logic           m1_req_valid, m1_req_ready, m1_req_we, m1_rsp_valid;
  logic [AW-1:0]  m1_req_addr;
  logic [7:0]     m1_req_wdata, m1_rsp_rdata;
  logic           ram_en, ram_we;
  logic [AW-1:0]  ram_addr;
  logic [7:0]     ram_wdata;
  logic [7:0]     ram_rdata = 8'h00;

  logic           f_v0 = 1'b0, f_v1 = 1'b0, f_m0_ready, f_m1_ready;
  logic [AW-1:0]  f_a0 = '0, f_a1 = '0, f_ram_addr;
  logic           f_ram_en, f_ram_we, f_m0_rsp_valid, f_m1_rsp_valid;
  logic [7:0]     f_ram_wdata, f_m0_rsp_rdata, f_m1_rsp_rdata;
  logic [7:0]     f_ram_rdata = 8'h3C;

  logic           p_valid [2];
  logic           p_we    [2];
  logic           p_done  [2];
  logic [AW-1:0]  p_addr  [2];
  logic [7:0]     p_wd    [2];

  assign m0_req_valid = p_valid[0];
  assign m0_req_we    = p_we[0];
  assign m0_req_addr  = p_addr[0];
  assign m0_req_wdata = p_wd[0];
  assign m1_req_valid = p_valid[1];
  assign m1_req_we    = p_we[1];
  assign m1_req_addr  = p_addr[1];
  assign m1_req_wdata = p_wd[1];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   model_last_m1 = 1'b1;
  cmd_t cmd_q[$];
  rsp_t rsp0_q[$];
  rsp_t rsp1_q[$];
  logic [7:0] mem     [logic [AW-1:0]];
  logic [7:0] ref_mem [logic [AW-1:0]];

  ram_port_arbiter #(.ram_addr_width(AW), .prio_mode(0)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
    .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
    .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  ram_port_arbiter #(.ram_addr_width(AW), .prio_mode(1)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req_valid(f_v0), .m0_req_ready(f_m0_ready), .m0_req_we(1'b0),
    .m0_req_addr(f_a0), .m0_req_wdata(8'h00),
    .m0_rsp_valid(f_m0_rsp_valid), .m0_rsp_rdata(f_m0_rsp_rdata),
    .m1_req_valid(f_v1), .m1_req_ready(f_m1_ready), .m1_req_we(1'b0),
    .m1_req_addr(f_a1), .m1_req_wdata(8'h00),
    .m1_rsp_valid(f_m1_rsp_valid), .m1_rsp_rdata(f_m1_rsp_rdata),
    .ram_en(f_ram_en), .ram_we(f_ram_we), .ram_addr(f_ram_addr), .ram_wdata(f_ram_wdata),
    .ram_rdata(f_ram_rdata)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [7:0] ref_read(logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return AW'(19'h7FFFF);
      1:       return '0;
      default: return AW'($urandom_range(0, 31));
    endcase
  endfunction

  // Synchronous-read byte RAM seen by the main DUT
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] = ram_wdata;
      else        ram_rdata <= mem.exists(ram_addr) ? mem[ram_addr] : 8'h00;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: RAM commands and responses are due on the exact cycle recorded at accept time
  always @(negedge clk) begin : monitor
    cmd_t c;
    rsp_t r;
    bit   exp_v;
    if (mon_en) begin
      while (cmd_q.size() > 0 && cmd_q[0].cyc < cyc) void'(cmd_q.pop_front());
      while (rsp0_q.size() > 0 && rsp0_q[0].cyc < cyc) void'(rsp0_q.pop_front());
      while (rsp1_q.size() > 0 && rsp1_q[0].cyc < cyc) void'(rsp1_q.pop_front());

      exp_v = (cmd_q.size() > 0) && (cmd_q[0].cyc == cyc);
      chk("ram_en", 32'(ram_en), 32'(exp_v));
      chk("we_without_en", 32'(ram_we & ~ram_en), 32'd0);
      if (exp_v) begin
        c = cmd_q.pop_front();
        if (ram_en) begin
          chk("ram_we", 32'(ram_we), 32'(c.we));
          chk("ram_addr", 32'(ram_addr), 32'(c.addr));
          if (c.we) chk("ram_wdata", 32'(ram_wdata), 32'(c.data));
        end
      end

      exp_v = (rsp0_q.size() > 0) && (rsp0_q[0].cyc == cyc);
      chk("m0_rsp_valid", 32'(m0_rsp_valid), 32'(exp_v));
      if (exp_v) begin
        r = rsp0_q.pop_front();
        chk("m0_rsp_rdata", 32'(m0_rsp_rdata), 32'(r.data));
      end

      exp_v = (rsp1_q.size() > 0) && (rsp1_q[0].cyc == cyc);
      chk("m1_rsp_valid", 32'(m1_rsp_valid), 32'(exp_v));
      if (exp_v) begin
        r = rsp1_q.pop_front();
        chk("m1_rsp_rdata", 32'(m1_rsp_rdata), 32'(r.data));
      end
    end
  end

  task automatic set_req(input int m, input logic we, input logic [AW-1:0] a, input logic [7:0] d);
    p_we[m]    = we;
    p_addr[m]  = a;
    p_wd[m]    = d;
    p_valid[m] = 1'b1;
    p_done[m]  = 1'b0;
  endtask

  // Drive one cycle of requester activity just after the rising edge
  task automatic applyStimulus(input bit do_rst, input int pct);
    @(posedge clk);
    #1;
    rst = do_rst;
    for (int m = 0; m < 2; m++) begin
      if (p_done[m]) begin
        p_valid[m] = 1'b0;
        p_done[m]  = 1'b0;
      end
    end
    if (do_rst) begin
      for (int i = cmd_q.size() - 1; i >= 0; i--) if (cmd_q[i].cyc > cyc) cmd_q.delete(i);
      for (int i = rsp0_q.size() - 1; i >= 0; i--) if (rsp0_q[i].cyc > cyc) rsp0_q.delete(i);
      for (int i = rsp1_q.size() - 1; i >= 0; i--) if (rsp1_q[i].cyc > cyc) rsp1_q.delete(i);
    end
    for (int m = 0; m < 2; m++) begin
      if (!p_valid[m] && int'($urandom_range(0, 99)) < pct)
        set_req(m, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
    end
  endtask

  // Predict the grant from the arbitration rules, compare, and queue the downstream effects
  task automatic checkOutput();
    bit   e0, e1;
    int   m;
    cmd_t c;
    rsp_t r;
    @(negedge clk);
    e0 = 1'b0;
    e1 = 1'b0;
    if (!rst) begin
      if (p_valid[0] && p_valid[1]) begin
        if (model_last_m1) e0 = 1'b1;
        else               e1 = 1'b1;
      end else begin
        e0 = p_valid[0];
        e1 = p_valid[1];
      end
    end
    chk("m0_req_ready", 32'(m0_req_ready), 32'(e0));
    chk("m1_req_ready", 32'(m1_req_ready), 32'(e1));
    if (e0 || e1) begin
      m      = e1 ? 1 : 0;
      c.cyc  = cyc + 1;
      c.we   = p_we[m];
      c.addr = p_addr[m];
      c.data = p_wd[m];
      cmd_q.push_back(c);
      if (p_we[m]) begin
        ref_mem[p_addr[m]] = p_wd[m];
      end else begin
        r.cyc  = cyc + 2;
        r.data = ref_read(p_addr[m]);
        if (m == 0) rsp0_q.push_back(r);
        else        rsp1_q.push_back(r);
      end
      model_last_m1 = (m == 1);
      p_done[m]     = 1'b1;
    end
    if (rst) model_last_m1 = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 0);
      checkOutput();
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      p_valid[m] = 1'b0;
      p_we[m]    = 1'b0;
      p_done[m]  = 1'b0;
      p_addr[m]  = '0;
      p_wd[m]    = 8'h00;
    end
    mem[19'h00010]     = 8'h5A;
    ref_mem[19'h00010] = 8'h5A;

    $display("[TB] reset");
    applyStimulus(1'b1, 0);
    checkOutput();
    mon_en = 1'b1;
    applyStimulus(1'b1, 0);
    checkOutput();

    $display("[TB] single m0 read of 0x00010");
    applyStimulus(1'b0, 0);
    set_req(0, 1'b0, 19'h00010, 8'h00);
    checkOutput();
    idle(3);

    $display("[TB] m1 write 0xA5 to 0x7FFFF then m0 read back");
    applyStimulus(1'b0, 0);
    set_req(1, 1'b1, 19'h7FFFF, 8'hA5);
    checkOutput();
    applyStimulus(1'b0, 0);
    set_req(0, 1'b0, 19'h7FFFF, 8'h00);
    checkOutput();
    idle(3);

    $display("[TB] round-robin from reset with both requesters busy");
    applyStimulus(1'b1, 100);
    checkOutput();
    applyStimulus(1'b1, 100);
    checkOutput();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 100);
      checkOutput();
    end
    idle(4);

    $display("[TB] reset right after a read accept");
    applyStimulus(1'b0, 0);
    set_req(0, 1'b0, 19'h00010, 8'h00);
    checkOutput();
    applyStimulus(1'b1, 100);
    checkOutput();
    applyStimulus(1'b1, 100);
    checkOutput();
    applyStimulus(1'b0, 0);
    checkOutput();
    idle(4);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 199) == 0, int'($urandom_range(20, 100)));
      checkOutput();
    end
    idle(8);
    chk("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
    chk("rsp0_q_drained", 32'(rsp0_q.size()), 32'd0);
    chk("rsp1_q_drained", 32'(rsp1_q.size()), 32'd0);

    $display("[TB] fixed-priority instance");
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      f_v0 = 1'b1;
      f_v1 = 1'b1;
      f_a0 = AW'(100 + i);
      f_a1 = AW'(200 + i);
      @(negedge clk);
      chk("fp_m0_ready", 32'(f_m0_ready), 32'd1);
      chk("fp_m1_ready", 32'(f_m1_ready), 32'd0);
      chk("fp_ram_we", 32'(f_ram_we), 32'd0);
      chk("fp_m1_rsp_valid", 32'(f_m1_rsp_valid), 32'd0);
      if (i > 0) begin
        chk("fp_ram_en", 32'(f_ram_en), 32'd1);
        chk("fp_ram_addr", 32'(f_ram_addr), 32'(100 + i - 1));
        chk("fp_ram_wdata", 32'(f_ram_wdata), 32'd0);
      end
      if (i > 1) begin
        chk("fp_m0_rsp_valid", 32'(f_m0_rsp_valid), 32'd1);
        chk("fp_m0_rsp_rdata", 32'(f_m0_rsp_rdata), 32'h3C);
        chk("fp_m1_rsp_rdata", 32'(f_m1_rsp_rdata), 32'h3C);
      end
    end
    @(posedge clk);
    #1;
    f_v0 = 1'b0;
    @(negedge clk);
    chk("fp_m1_ready_after_m0_drop", 32'(f_m1_ready), 32'd1);
    chk("fp_m0_ready_after_m0_drop", 32'(f_m0_ready), 32'd0);
    chk("fp_ram_addr_last_m0", 32'(f_ram_addr), 32'd105);
    @(posedge clk);
    #1;
    f_v1 = 1'b0;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter ram_addr_width, default 19, RAM byte-address width.
REQ-002 SHALL have parameter prio_mode, default 0, arbitration policy: 0 = round-robin, 1 = fixed priority to m0.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports m0_req_valid / m1_req_valid  input  1  requester has a pending access.
REQ-006 SHALL have ports m0_req_ready / m1_req_ready  output  1  access accepted this cycle.
REQ-007 SHALL have ports m0_req_we / m1_req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports m0_req_addr / m1_req_addr  input  ram_addr_width  byte address.
REQ-009 SHALL have ports m0_req_wdata / m1_req_wdata  input  8  write byte.
REQ-010 SHALL have ports m0_rsp_valid / m1_rsp_valid  output  1  read data valid, one-cycle pulse.
REQ-011 SHALL have ports m0_rsp_rdata / m1_rsp_rdata  output  8  read byte.
REQ-012 SHALL have ports ram_en, ram_we  output  1  RAM port enable / write enable.
REQ-013 SHALL have port ram_addr  output  ram_addr_width  RAM address.
REQ-014 SHALL have port ram_wdata  output  8  RAM write byte.
REQ-015 SHALL have port ram_rdata  input  8  RAM read byte, synchronous read, valid the cycle after ram_en sampled.

Function
REQ-016 SHALL assert at most one of m0_req_ready, m1_req_ready per cycle; ready is combinational from req_valid and the last_grant register.
REQ-017 SHALL grant a lone valid requester in the same cycle, regardless of last_grant or prio_mode.
REQ-018 SHALL, in round-robin mode with both valid, grant the requester not recorded in last_grant.
REQ-019 SHALL, in fixed mode with both valid, always grant m0 (m1 may starve).
REQ-020 SHALL update last_grant only on an accept (valid & ready); idle cycles leave it unchanged.
REQ-021 SHALL, for an accept in cycle N, drive ram_en=1 with the registered we/addr/wdata in cycle N+1; ram_en=0 and ram_we=0 in cycles without a registered command.
REQ-022 SHALL never drive ram_we=1 while ram_en=0.
REQ-023 SHALL, for a read accepted in cycle N, pulse the issuing requester's rsp_valid in cycle N+2 with rsp_rdata equal to ram_rdata in that cycle.
REQ-024 SHALL produce no rsp_valid for writes.
REQ-025 SHALL sustain one accept per cycle with back-to-back accepts and interleaved requesters, keeping response order and routing correct via a two-stage owner/read tag pipeline.
REQ-026 SHALL require requesters to hold payload stable while valid & !ready; rsp has no backpressure.
REQ-027 SHALL drive both rsp_rdata outputs from ram_rdata every cycle; the value is meaningful only with rsp_valid.

Reset
REQ-028 SHALL, on a clock edge with rst=1, clear ram_en, ram_we, ram_addr, ram_wdata, both rsp_valid and the tag pipeline to 0, and set last_grant to m1 so m0 wins the first tie.
REQ-029 SHALL force both req_ready to 0 while rst=1.
REQ-030 SHALL discard in-flight accesses on reset; no rsp_valid pulse for them.

Verification
REQ-031 SHALL pass: m0 read addr 0x00010 accepted in cycle N, RAM holds 0x5A -> ram_en=1 and addr=0x00010 in N+1; m0_rsp_valid=1 and rdata=0x5A in N+2; m1_rsp_valid stays 0.
REQ-032 SHALL pass: both valid continuously, prio_mode=0, from reset -> grants m0,m1,m0,m1; ram_addr alternates accordingly.
REQ-033 SHALL pass: both valid, prio_mode=1 -> m0 granted every cycle, m1_req_ready stays 0 until m0_req_valid drops.
REQ-034 SHALL pass: m1 write 0xA5 to 0x7FFFF, then m0 read 0x7FFFF next cycle -> ram_we=1 with wdata 0xA5, then m0_rsp_valid with rdata 0xA5; no rsp for the write.
REQ-035 SHALL pass: rst=1 in the cycle after a read accept -> ram_en=0 and no rsp_valid after the reset edge; first tie after reset release goes to m0.
